// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and the group-carry lookahead helper for the pipelined CLA adder.
package cla_pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam int unsigned CLA_GRP = 4;
  localparam int unsigned MaxGroups = 16;

  // Carry into group j in sum-of-products form: the all-propagate term plus one generate
  // term per lower group. No carry passes through intermediate group carries.
  function automatic logic group_carry(input logic [MaxGroups-1:0] p,
                                       input logic [MaxGroups-1:0] g,
                                       input logic                 cin,
                                       input int unsigned          j);
    logic c;
    logic t;
    c = cin;
    for (int unsigned i = 0; i < j; i++) begin
      c = c & p[i];
    end
    for (int unsigned i = 0; i < j; i++) begin
      t = g[i];
      for (int unsigned m = i + 1; m < j; m++) begin
        t = t & p[m];
      end
      c = c | t;
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group with group propagate/generate outputs.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       grp_p,
  output logic       grp_g,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign cout  = grp_g | (grp_p & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract unit: one SLICE-bit carry-lookahead stage per pipeline register,
// valid/ready on both sides with a single global advance enable.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NumStages = WIDTH / SLICE;
  localparam int unsigned NumGroups = SLICE / CLA_GRP;

  // Per-stage state: full operand words travel along so every stage sees its own slice,
  // and the sum word accumulates completed lower slices.
  logic [WIDTH-1:0] a_q     [NumStages];
  logic [WIDTH-1:0] b_q     [NumStages];
  logic [WIDTH-1:0] sum_q   [NumStages];
  logic             c_q     [NumStages];
  logic             valid_q [NumStages];
  logic             ovf_q;
  logic             zero_q;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign out_valid = valid_q[NumStages-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Mode is fully resolved here: later stages only ever add.
  assign b_eff   = (in_mode == MODE_SUB) ? ~in_b : in_b;
  assign cin_eff = (in_mode == MODE_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    localparam int unsigned Lo = k * SLICE;

    logic [WIDTH-1:0]     a_prev;
    logic [WIDTH-1:0]     b_prev;
    logic [WIDTH-1:0]     sum_prev;
    logic [WIDTH-1:0]     sum_nxt;
    logic                 c_prev;
    logic                 v_prev;
    logic [SLICE-1:0]     sa;
    logic [SLICE-1:0]     sb;
    logic [SLICE-1:0]     ssum;
    logic [NumGroups-1:0] gp;
    logic [NumGroups-1:0] gg;
    logic [NumGroups-1:0] gcin;
    logic                 gco [NumGroups];
    logic                 scout;

    if (k == 0) begin : g_first
      assign a_prev   = in_a;
      assign b_prev   = b_eff;
      assign sum_prev = '0;
      assign c_prev   = cin_eff;
      assign v_prev   = in_valid;
    end else begin : g_next
      assign a_prev   = a_q[k-1];
      assign b_prev   = b_q[k-1];
      assign sum_prev = sum_q[k-1];
      assign c_prev   = c_q[k-1];
      assign v_prev   = valid_q[k-1];
    end

    assign sa = a_prev[Lo +: SLICE];
    assign sb = b_prev[Lo +: SLICE];

    assign gcin[0] = c_prev;
    for (genvar j = 1; j < NumGroups; j++) begin : g_look
      assign gcin[j] = group_carry(MaxGroups'(gp), MaxGroups'(gg), c_prev, j);
    end

    for (genvar j = 0; j < NumGroups; j++) begin : g_grp
      cla_group4 u_grp (
        .a     (sa[j*CLA_GRP +: CLA_GRP]),
        .b     (sb[j*CLA_GRP +: CLA_GRP]),
        .cin   (gcin[j]),
        .sum   (ssum[j*CLA_GRP +: CLA_GRP]),
        .grp_p (gp[j]),
        .grp_g (gg[j]),
        .cout  (gco[j])
      );
    end
    assign scout = gco[NumGroups-1];

    always_comb begin
      sum_nxt = sum_prev;
      sum_nxt[Lo +: SLICE] = ssum;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        c_q[k]     <= 1'b0;
      end else if (adv) begin
        valid_q[k] <= v_prev;
        a_q[k]     <= a_prev;
        b_q[k]     <= b_prev;
        sum_q[k]   <= sum_nxt;
        c_q[k]     <= scout;
      end
    end

    if (k == NumStages - 1) begin : g_last
      logic cmsb;
      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
      assign cmsb = sa[SLICE-1] ^ sb[SLICE-1] ^ ssum[SLICE-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= cmsb ^ scout;
          zero_q <= ~|sum_nxt;
        end
      end
    end
  end

  assign out_sum  = sum_q[NumStages-1];
  assign out_cout = c_q[NumStages-1];
  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;

endmodule
